stim_gen: RTL and testbench



---
 rtl/stim_gen_pkg.sv | 19 +
 rtl/stim_lfsr.sv | 13 +
 rtl/stim_gen.sv | 162 ++++++++++++++++
 tb/tb_stim_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_gen_pkg.sv
// Shared encodings for the stim_gen address/data stimulus generator.
`timescale 1ns/1ps
package stim_gen_pkg;

   localparam logic [1:0] MODE_INCR  = 2'd0;
   localparam logic [1:0] MODE_DECR  = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

   localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;

   // Channel index width; a single channel still gets a 1-bit index.
   function automatic int ch_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stim_lfsr.sv
// Single-step right-shifting Galois LFSR next-state function.
`timescale 1ns/1ps
module stim_lfsr #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h8020_0003)
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   assign nxt = (cur >> 1) ^ (cur[0] ? POLY : '0);

endmodule

// File: rtl/stim_gen.sv
// Multi-channel round-robin address/data stimulus generator on a valid/ready stream.
// Define STIM_GEN_STALL_EN to insert pseudo-random bubbles before out_valid rises.
`timescale 1ns/1ps
module stim_gen
   import stim_gen_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 32,
   parameter int          NUM_CH      = 4,
   parameter int          COUNT_WIDTH = 16,
   parameter int          ADDR_STEP   = 1,
   parameter logic [31:0] LFSR_POLY   = DEF_LFSR_POLY
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        start,
   input  logic [1:0]                  cfg_mode,
   input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
   input  logic [DATA_WIDTH-1:0]       cfg_seed,
   input  logic [COUNT_WIDTH-1:0]      cfg_count,
   output logic                        busy,
   output logic                        done,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ch_bits(NUM_CH)-1:0]  out_ch,
   output logic [ADDR_WIDTH-1:0]       out_addr,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        out_last
);

   localparam int CH_W   = ch_bits(NUM_CH);
   localparam int BEAT_W = COUNT_WIDTH + $clog2(NUM_CH) + 1;

   state_e                              state_q, state_d;
   logic                                launch_q;
   logic [1:0]                          mode_q;
   logic [BEAT_W-1:0]                   total_q, beat_q;
   logic [CH_W-1:0]                     ch_q;
   logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   addr_q, addr_nxt;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]   data_q, data_nxt, lfsr_nxt, seed_init;
   logic                                last_beat, accept, run_gate;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      stim_lfsr #(.WIDTH(DATA_WIDTH), .POLY(DATA_WIDTH'(LFSR_POLY))) u_lfsr (
         .cur (data_q[c]),
         .nxt (lfsr_nxt[c])
      );

      // An LFSR seed of zero would lock up, so it is promoted to 1.
      assign seed_init[c] = (cfg_mode != MODE_LFSR) ? cfg_seed + DATA_WIDTH'(c) :
                            ((cfg_seed ^ DATA_WIDTH'(c)) == '0) ? DATA_WIDTH'(1) :
                            (cfg_seed ^ DATA_WIDTH'(c));

      assign addr_nxt[c] = (mode_q == MODE_DECR) ? addr_q[c] - ADDR_WIDTH'(ADDR_STEP)
                                                 : addr_q[c] + ADDR_WIDTH'(ADDR_STEP);

      assign data_nxt[c] = (mode_q == MODE_INCR) ? data_q[c] + DATA_WIDTH'(1) :
                           (mode_q == MODE_DECR) ? data_q[c] - DATA_WIDTH'(1) :
                           (mode_q == MODE_LFSR) ? lfsr_nxt[c] : data_q[c];
   end

`ifdef STIM_GEN_STALL_EN
   logic [15:0] stall_q, stall_nxt;
   logic        held_q;

   stim_lfsr #(.WIDTH(16), .POLY(16'hB400)) u_stall (
      .cur (stall_q),
      .nxt (stall_nxt)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         stall_q <= 16'hACE1;
         held_q  <= 1'b0;
      end else begin
         stall_q <= stall_nxt;
         held_q  <= out_valid && !out_ready;
      end
   end

   // A pending beat is never withdrawn; bubbles only delay the rise of valid.
   assign run_gate = held_q || !stall_q[0];
`else
   assign run_gate = 1'b1;
`endif

   assign last_beat = (beat_q == total_q - BEAT_W'(1));
   assign accept    = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_ch    = '0;
      out_addr  = '0;
      out_data  = '0;
      case (state_q)
         IDLE: if (launch_q) state_d = (total_q == '0) ? FIN : RUN;
         RUN: begin
            busy      = 1'b1;
            out_valid = run_gate;
            out_ch    = ch_q;
            out_addr  = addr_q[ch_q];
            out_data  = data_q[ch_q];
            out_last  = last_beat;
            if (out_valid && out_ready && last_beat) state_d = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Config is captured on the start edge; the following IDLE cycle launches the run.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= IDLE;
         launch_q <= 1'b0;
         mode_q   <= MODE_INCR;
         total_q  <= '0;
         beat_q   <= '0;
         ch_q     <= '0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (launch_q) begin
                  launch_q <= 1'b0;
               end else if (start) begin
                  launch_q <= 1'b1;
                  mode_q   <= cfg_mode;
                  total_q  <= BEAT_W'(cfg_count) * BEAT_W'(NUM_CH);
                  beat_q   <= '0;
                  ch_q     <= '0;
                  data_q   <= seed_init;
                  for (int c = 0; c < NUM_CH; c++) addr_q[c] <= cfg_base_addr;
               end
            end
            RUN: begin
               if (accept) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  ch_q   <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                  for (int c = 0; c < NUM_CH; c++) begin
                     if (ch_q == CH_W'(c)) begin
                        addr_q[c] <= addr_nxt[c];
                        data_q[c] <= data_nxt[c];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: one single-channel and one four-channel instance.
`timescale 1ns/1ps
module tb_stim_gen;
   import stim_gen_pkg::*;

   typedef struct packed {
      logic [1:0]  ch;
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int    vec_cnt = 0, err_cnt = 0;
   beat_t q1[$], q4[$];
   int    last_cyc1 = 0, last_cyc4 = 0, st_cyc = 0;

   logic        rst1, start1, ready1, busy1, done1, valid1, last1;
   logic [1:0]  mode1;
   logic [31:0] base1, seed1, addr1, data1;
   logic [15:0] count1;
   logic [0:0]  ch1;

   logic        rst4, start4, ready4, busy4, done4, valid4, last4;
   logic [1:0]  mode4;
   logic [31:0] base4, seed4, addr4, data4;
   logic [15:0] count4;
   logic [1:0]  ch4;

   stim_gen #(.NUM_CH(1)) u_dut1 (
      .sys_clk(sys_clk), .sys_rst(rst1), .start(start1), .cfg_mode(mode1),
      .cfg_base_addr(base1), .cfg_seed(seed1), .cfg_count(count1),
      .busy(busy1), .done(done1), .out_valid(valid1), .out_ready(ready1),
      .out_ch(ch1), .out_addr(addr1), .out_data(data1), .out_last(last1)
   );

   stim_gen #(.NUM_CH(4)) u_dut4 (
      .sys_clk(sys_clk), .sys_rst(rst4), .start(start4), .cfg_mode(mode4),
      .cfg_base_addr(base4), .cfg_seed(seed4), .cfg_count(count4),
      .busy(busy4), .done(done4), .out_valid(valid4), .out_ready(ready4),
      .out_ch(ch4), .out_addr(addr4), .out_data(data4), .out_last(last4)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int sel, input logic [1:0] ch, input logic [31:0] addr,
                       input logic [31:0] data, input logic last);
      beat_t b;
      b = '{ch: ch, addr: addr, data: data, last: last};
      if (sel == 1) q1.push_back(b); else q4.push_back(b);
   endtask

   task automatic pop_check(input int sel, input beat_t act);
      beat_t e;
      if ((sel == 1 && q1.size() == 0) || (sel == 4 && q4.size() == 0)) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL beat_u%0d: got %h expected no beat", sel, act);
      end else begin
         e = (sel == 1) ? q1.pop_front() : q4.pop_front();
         check($sformatf("beat_u%0d", sel), 128'(act), 128'(e));
      end
   endtask

   // Monitors: pop on every accepted beat, and hold stalled beats to their first presentation.
   beat_t hold1, hold4;
   bit    hold1_v = 0, hold4_v = 0;

   always @(negedge sys_clk) begin
      beat_t a;
      a = '{ch: 2'(ch1), addr: addr1, data: data1, last: last1};
      if (!rst1 && valid1) begin
         if (hold1_v) check("u1_hold", 128'(a), 128'(hold1));
         if (ready1) begin
            pop_check(1, a);
            if (a.last) last_cyc1 = cyc;
            hold1_v = 0;
         end else begin
            hold1   = a;
            hold1_v = 1;
         end
      end else begin
         if (hold1_v && !rst1) check("u1_withdrawn", 128'(valid1), 128'(1));
         hold1_v = 0;
      end
   end

   always @(negedge sys_clk) begin
      beat_t a;
      a = '{ch: ch4, addr: addr4, data: data4, last: last4};
      if (!rst4 && valid4) begin
         if (hold4_v) check("u4_hold", 128'(a), 128'(hold4));
         if (ready4) begin
            pop_check(4, a);
            if (a.last) last_cyc4 = cyc;
            hold4_v = 0;
         end else begin
            hold4   = a;
            hold4_v = 1;
         end
      end else begin
         if (hold4_v && !rst4) check("u4_withdrawn", 128'(valid4), 128'(1));
         hold4_v = 0;
      end
   end

   task automatic launch(input int sel, input logic [1:0] mode, input logic [31:0] base,
                         input logic [31:0] seed, input int cnt);
      @(posedge sys_clk); #1;
      if (sel == 1) begin
         mode1 = mode; base1 = base; seed1 = seed; count1 = 16'(cnt); start1 = 1'b1;
      end else begin
         mode4 = mode; base4 = base; seed4 = seed; count4 = 16'(cnt); start4 = 1'b1;
      end
      @(posedge sys_clk); #1;
      st_cyc = cyc;
      start1 = 1'b0;
      start4 = 1'b0;
   endtask

   // when: 1 = cycle after the last beat is accepted, 2 = two cycles after start.
   task automatic wait_done(input int sel, input int budget, input int when, input string name);
      bit seen = 0;
      int at   = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge sys_clk);
         if ((sel == 1) ? done1 : done4) begin
            seen = 1;
            at   = cyc;
         end
      end
      check({name, "_done"}, 128'(seen), 128'(1));
      if (seen) begin
         if (when == 1) check({name, "_done_cyc"}, 128'(at), 128'((sel == 1 ? last_cyc1 : last_cyc4) + 1));
         if (when == 2) check({name, "_done_cyc"}, 128'(at), 128'(st_cyc + 1));
         @(negedge sys_clk);
         check({name, "_pulse"}, 128'((sel == 1) ? done1 : done4), 128'(0));
         check({name, "_drained"}, 128'((sel == 1) ? q1.size() : q4.size()), 128'(0));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      err_cnt++;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat;
      int         n;
      bit         dseen;
      pat = 4'b1001;
      rst1 = 1; rst4 = 1; start1 = 0; start4 = 0; ready1 = 1; ready4 = 1;
      mode1 = '0; base1 = '0; seed1 = '0; count1 = '0;
      mode4 = '0; base4 = '0; seed4 = '0; count4 = '0;
      repeat (3) @(posedge sys_clk);
      #1; rst1 = 0; rst4 = 0;
      @(negedge sys_clk);
      check("rst_u1", 128'({busy1, done1, valid1, last1, ch1, addr1, data1}), 128'(0));
      check("rst_u4", 128'({busy4, done4, valid4, last4, ch4, addr4, data4}), 128'(0));

      // Single channel increment with latency checks.
      for (int i = 0; i < 4; i++) push(1, 2'd0, 32'h100 + 32'(i), 32'(i), i == 3);
      launch(1, MODE_INCR, 32'h100, 32'h0, 4);
      @(negedge sys_clk);
      check("t1_lat0", 128'({valid1, busy1}), 128'(2'b00));
      @(negedge sys_clk);
      check("t1_lat1", 128'({valid1, busy1}), 128'(2'b11));
      wait_done(1, 50, 1, "t1");

      // Decrement wraps through zero.
      push(1, 2'd0, 32'h0, 32'h0, 1'b0);
      push(1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      launch(1, MODE_DECR, 32'h0, 32'h0, 2);
      wait_done(1, 50, 1, "t3");

      // LFSR with zero seed forced to 1, poly 0x80200003.
      push(1, 2'd0, 32'h40, 32'h0000_0001, 1'b0);
      push(1, 2'd0, 32'h41, 32'h8020_0003, 1'b0);
      push(1, 2'd0, 32'h42, 32'hC030_0002, 1'b0);
      push(1, 2'd0, 32'h43, 32'h6018_0001, 1'b1);
      launch(1, MODE_LFSR, 32'h40, 32'h0, 4);
      wait_done(1, 50, 1, "t6");

      // Zero count: no beats, done two cycles after start.
      launch(1, MODE_INCR, 32'h0, 32'h5, 0);
      wait_done(1, 10, 2, "t5a");

      // Reset while beat 3 of 8 is pending.
      push(1, 2'd0, 32'h200, 32'h50, 1'b0);
      push(1, 2'd0, 32'h201, 32'h51, 1'b0);
      launch(1, MODE_INCR, 32'h200, 32'h50, 8);
      n = 0;
      for (int i = 0; i < 50 && n < 2; i++) begin
         @(negedge sys_clk);
         if (valid1 && ready1) n++;
      end
      @(posedge sys_clk); #1; ready1 = 0;
      @(negedge sys_clk);
      check("t5b_beat3", 128'({valid1, addr1, data1}), 128'({1'b1, 32'h202, 32'h52}));
      @(posedge sys_clk); #1; rst1 = 1;
      @(posedge sys_clk); #1; rst1 = 0;
      @(negedge sys_clk);
      check("t5b_rst", 128'({busy1, done1, valid1, last1, ch1, addr1, data1}), 128'(0));
      dseen = 0;
      repeat (6) begin
         @(negedge sys_clk);
         if (done1 || valid1) dseen = 1;
      end
      check("t5b_quiet", 128'(dseen), 128'(0));
      check("t5b_drained", 128'(q1.size()), 128'(0));
      ready1 = 1;

      // Four channels round-robin.
      for (int i = 0; i < 8; i++) push(4, 2'(i % 4), 32'(i / 4), 32'h10 + 32'(i % 4) + 32'(i / 4), i == 7);
      launch(4, MODE_INCR, 32'h0, 32'h10, 2);
      wait_done(4, 50, 1, "t2");

      // Same run under a 1-0-0-1 ready pattern, with an ignored mid-run start.
      for (int i = 0; i < 8; i++) push(4, 2'(i % 4), 32'(i / 4), 32'h10 + 32'(i % 4) + 32'(i / 4), i == 7);
      launch(4, MODE_INCR, 32'h0, 32'h10, 2);
      mode4 = MODE_DECR; count4 = 16'd5;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               @(posedge sys_clk); #1;
               ready4 = pat[i % 4];
               start4 = (i == 5);
            end
            ready4 = 1;
         end
         wait_done(4, 60, 1, "t4");
      join
      repeat (3) @(negedge sys_clk);
      check("t4_idle", 128'({busy4, valid4}), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
